imem_loader: RTL

Boot-time writer for the 4 KB instruction memory at 0xBFC00000–0xBFC00FFF. Accepts a byte stream (e.g. from a UART receiver) over a valid/ready handshake, packs bytes little-endian into 32-bit words and issues one word write per four bytes on the instruction memory write port. Holds the CPU in reset while loading, then reports done or error.

---
 rtl/imem_pkg.sv | 26 ++
 rtl/imem_word_packer.sv | 56 +++++
 rtl/imem_loader.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// =============================================================================
//  Module   : imem_pkg
//  Purpose  : Shared instruction-memory constants and the loader state type.
//  Revision : 1.0
// =============================================================================
`default_nettype none

package imem_pkg;

    localparam logic [31:0] BASE_ADDR = 32'hBFC00000;
    localparam logic [31:0] TOP_ADDR  = 32'hBFC00FFF;
    localparam int          MEM_SIZE  = 4096;
    localparam int          LEN_W     = 13;
    localparam int          WIDX_W    = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_word_packer.sv
// =============================================================================
//  Module   : imem_word_packer
//  Purpose  : Packs accepted bytes little-endian into a 32-bit word and counts
//             payload bytes; each word's first byte zero-fills the upper lanes.
//  Revision : 1.0
// =============================================================================
`default_nettype none

module imem_word_packer
    import imem_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic             accept_i,
    input  logic [7:0]       byte_i,
    output logic [31:0]      word_o,
    output logic [LEN_W-1:0] count_o
);

    logic [31:0]      word_q, word_d;
    logic [LEN_W-1:0] count_q, count_d;

    // Lanes follow the running count because every word starts 4-byte aligned.
    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (accept_i) begin
            count_d = count_q + 1'b1;
            case (count_q[1:0])
                2'd0:    word_d = {24'h0, byte_i};
                2'd1:    word_d = {word_q[31:16], byte_i, word_q[7:0]};
                2'd2:    word_d = {word_q[31:24], byte_i, word_q[15:0]};
                default: word_d = {byte_i, word_q[23:0]};
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            word_q  <= '0;
            count_q <= '0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    assign word_o  = word_q;
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// =============================================================================
//  Module   : imem_loader
//  Purpose  : Boot-time byte-stream loader for the instruction memory; holds
//             the CPU in reset while loading. Optional trailing checksum byte
//             enabled by IMEM_LOADER_CHECKSUM_EN.
//  Revision : 1.0
// =============================================================================
`default_nettype none

module imem_loader
    import imem_pkg::loader_state_t, imem_pkg::ST_IDLE, imem_pkg::ST_LOAD,
           imem_pkg::ST_WRITE, imem_pkg::ST_CHECK, imem_pkg::ST_DONE,
           imem_pkg::LEN_W, imem_pkg::WIDX_W;
#(
    parameter logic [31:0] BASE_ADDR = imem_pkg::BASE_ADDR,
    parameter int          MEM_SIZE  = imem_pkg::MEM_SIZE
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [12:0] len_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        cpu_rst_o
);

    loader_state_t     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [31:0]       waddr_q, waddr_d;
    logic              ready_q, we_q, busy_q, done_q, done_d, err_q, err_d;
    logic              accept, len_ok, pk_clear, pk_accept;
    logic [LEN_W-1:0]  pk_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d, ck_byte_q, ck_byte_d;
    logic              ck_phase_q, ck_phase_d;
`endif

    assign accept = byte_valid_i & ready_q;
    assign len_ok = (len_i != '0) && (len_i <= LEN_W'(MEM_SIZE));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        widx_d    = widx_q;
        waddr_d   = waddr_q;
        done_d    = done_q;
        err_d     = err_q;
        pk_clear  = 1'b0;
        pk_accept = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        ck_byte_d  = ck_byte_q;
        ck_phase_d = ck_phase_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    done_d = 1'b0;
                    if (len_ok) begin
                        state_d  = ST_LOAD;
                        len_d    = len_i;
                        widx_d   = '0;
                        err_d    = 1'b0;
                        pk_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d      = '0;
                        ck_phase_d = 1'b0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (ck_phase_q) begin
                        ck_byte_d = byte_data_i;
                        state_d   = ST_CHECK;
                    end else begin
                        sum_d = sum_q + byte_data_i;
`endif
                        pk_accept = 1'b1;
                        if (pk_count[1:0] == 2'd3 || pk_count + 1'b1 == len_q) begin
                            state_d = ST_WRITE;
                            waddr_d = BASE_ADDR + {20'h0, widx_q, 2'b00};
                        end
`ifdef IMEM_LOADER_CHECKSUM_EN
                    end
`endif
                end
            end
            ST_WRITE: begin
                widx_d = widx_q + 1'b1;
                if (pk_count != len_q) begin
                    state_d = ST_LOAD;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d    = ST_LOAD;
                    ck_phase_d = 1'b1;
`else
                    state_d = ST_DONE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                state_d = ST_DONE;
                done_d  = (ck_byte_q == sum_q);
                err_d   = (ck_byte_q != sum_q);
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            waddr_q <= BASE_ADDR;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            waddr_q <= waddr_d;
            ready_q <= (state_d == ST_LOAD);
            we_q    <= (state_d == ST_WRITE);
            busy_q  <= (state_d == ST_LOAD) || (state_d == ST_WRITE) || (state_d == ST_CHECK);
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sum_q      <= '0;
            ck_byte_q  <= '0;
            ck_phase_q <= 1'b0;
        end else begin
            sum_q      <= sum_d;
            ck_byte_q  <= ck_byte_d;
            ck_phase_q <= ck_phase_d;
        end
    end
`endif

    imem_word_packer u_packer (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clear_i  (pk_clear),
        .accept_i (pk_accept),
        .byte_i   (byte_data_i),
        .word_o   (wdata_o),
        .count_o  (pk_count)
    );

    assign byte_ready_o = ready_q;
    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign busy_o       = busy_q;
    assign cpu_rst_o    = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

`default_nettype wire
